seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Sequencing controller for the board's 4-digit multiplexed seven-segment display. Accepts a binary value (0..9999) over a ready/valid-style load handshake and converts it serially to BCD (shift-add-3). It then time-multiplexes the four digits: each refresh tick it drives one BCD digit and its position select into the existing SevenSegDCD decoder. It owns refresh timing, digit buffering and out-of-range handling; the decoder stays purely combinational.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (must be >= 2)
VAL_W, 14, width of binary input value

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
load  in  1  request to display value; accepted only when ready=1
value  in  VAL_W  unsigned binary value to display
ready  out  1  controller idle; load accepted this cycle if asserted
done  out  1  one-cycle pulse when the new digits are committed to the display buffer
in_digit  out  5  digit code to decoder (0..9 BCD, 5'h1F = error glyph "E")
exp  out  3  digit position to decoder: 0 ones, 1 tens, 2 hundreds, 3 thousands; bit 2 always 0

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: ready=1, done=0, exp=0, refresh counter=0, all four display buffer digits=0. in_digit therefore reads 0, and the display shows "0000".
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: ready=1. On load=1, capture value into the shift register, clear the BCD accumulator and the shift count, and latch range_err = (value > 9999). Go to SHIFT.
  - SHIFT: ready=0. Runs for exactly VAL_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. After the VAL_W-th shift, go to COMMIT.
  - COMMIT: ready=0, done=1 for this cycle only. The display buffer loads the four BCD nibbles, or 5'h1F in all four positions if range_err. Go to IDLE.
- Latency: a load accepted at edge N leaves ready low for VAL_W+1 cycles (15 at default) and raises done in cycle N+VAL_W+1. The new digits are visible on in_digit from the cycle after the COMMIT edge.
- load is ignored while ready=0: no queueing, and value is not sampled.
- load with ready=1 in the same cycle that COMMIT completes cannot occur, because ready is 0 in COMMIT.
- The display buffer is only written in COMMIT. The old digits keep scanning throughout conversion, so the display never shows a partial result.
- Refresh:
  - A free-running counter counts 0..REFRESH_DIV-1 in every state.
  - On the cycle the counter equals REFRESH_DIV-1, it wraps to 0 and exp advances 0→1→2→3→0.
  - exp is registered.
  - in_digit = buffer[exp] is a combinational mux from registers, so exp and in_digit always change together.
- BCD width: 4 nibbles (16 bits). Values > 9999 are never converted into the display; the error pattern is shown instead.
- rst mid-conversion: abort immediately. Next cycle is IDLE with ready=1, the buffer is "0000", exp=0, the counter is 0, and no done pulse.
- No combinational path from load/value to any output.

Test Plan:
- Reset: assert rst 2 cycles with REFRESH_DIV=4 → ready=1, done=0, exp=0, in_digit=0. exp steps 0,1,2,3,0 every 4 cycles, and in_digit stays 0.
- Load 1234 at cycle N → ready=0 for cycles N+1..N+15 and done=1 at cycle N+15 only. The scan then shows in_digit=4,3,2,1 at exp=0,1,2,3.
- Load 9999 then 0 back-to-back (second load issued as soon as ready returns) → first commit shows 9,9,9,9 and second shows 0,0,0,0. Exactly two done pulses, 16 cycles apart.
- Out of range: load 12000 → after 15 cycles done=1, and all four positions show in_digit=5'h1F.
- Ignored load: load 5678 accepted, then pulse load with value 1111 at cycle N+5 → the display commits 5678, and 1111 never appears.
- Mid-conversion reset: load 4321, assert rst at cycle N+7 → no done pulse, ready=1 the cycle after reset, and the display reads 0000.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake and decoder drive bundle for the 4-digit seven-segment scan controller.
// The master side (the producer of values) drives load/value; the controller is the slave.
interface seven_seg_scan_ctrl_if #(
  parameter int unsigned VAL_W = 14
);
  logic             load;
  logic [VAL_W-1:0] value;
  logic             ready;
  logic             done;
  logic [4:0]       in_digit;
  logic [2:0]       exp;

  modport master (
    output load,
    output value,
    input  ready,
    input  done,
    input  in_digit,
    input  exp
  );

  modport slave (
    input  load,
    input  value,
    output ready,
    output done,
    output in_digit,
    output exp
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Serial binary-to-BCD converter (shift-add-3) feeding a buffered, time-multiplexed
// 4-digit seven-segment scan; out-of-range values show the error glyph on every digit.
module seven_seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned VAL_W       = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BCD_W     = DIGITS * NIB_W;
  localparam int unsigned CNT_W     = $clog2(VAL_W + 1);
  localparam int unsigned RC_W      = $clog2(REFRESH_DIV);
  localparam int unsigned MAX_VALUE = 9999;
  localparam int unsigned SH_W      = BCD_W + VAL_W;
  localparam logic [4:0]  ERR_GLYPH = 5'h1F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] bin;
  logic [BCD_W-1:0] bcd;
  logic [CNT_W-1:0] shift_cnt;
  logic             range_err;
  logic             ready;
  logic             done;

  logic [RC_W-1:0]  refresh_cnt;
  logic [1:0]       pos;
  logic [4:0]       disp [DIGITS];

  logic [BCD_W-1:0] bcd_adj;
  logic [SH_W-1:0]  shifted;
  logic             value_err;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [NIB_W-1:0] nib;
    r = b;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = b[i*NIB_W +: NIB_W];
      if (nib >= 4'd5) begin
        r[i*NIB_W +: NIB_W] = nib + 4'd3;
      end
    end
    return r;
  endfunction

  assign bcd_adj   = add3(bcd);
  assign shifted   = {bcd_adj, bin} << 1;
  assign value_err = 32'(bus.value) > 32'(MAX_VALUE);

  // Conversion sequencer with registered ready/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      range_err <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        disp[i] <= 5'd0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            bin       <= bus.value;
            bcd       <= '0;
            shift_cnt <= '0;
            range_err <= value_err;
            ready     <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd       <= shifted[SH_W-1:VAL_W];
          bin       <= shifted[VAL_W-1:0];
          shift_cnt <= shift_cnt + CNT_W'(1);
          if (shift_cnt == CNT_W'(VAL_W - 1)) begin
            done  <= 1'b1;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          // The display buffer only changes here, so scanning never shows a partial result.
          for (int i = 0; i < int'(DIGITS); i++) begin
            disp[i] <= range_err ? ERR_GLYPH : {1'b0, bcd[i*NIB_W +: NIB_W]};
          end
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running digit-slot timer and position select.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      pos         <= 2'd0;
    end else if (refresh_cnt == RC_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      pos         <= pos + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RC_W'(1);
    end
  end

  assign bus.ready    = ready;
  assign bus.done     = done;
  assign bus.exp      = {1'b0, pos};
  assign bus.in_digit = disp[pos];

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: a decimal-arithmetic model is checked every
// cycle, and literal expectations pin latency, scan contents and done spacing.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned RD = 4;
  localparam int unsigned VW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.VAL_W(VW)) bus ();

  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .VAL_W(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int lo_cnt = 0;
  int done_cnt = 0;
  int done_cyc [8];

  // Model state: cycles left with ready low, display digits, pending digits, slot time.
  bit m_valid = 1'b0;
  int m_left  = 0;
  int m_since = 0;
  int m_disp [4];
  int m_pend [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d required %0d", nm, cyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_since = 0;
      for (int i = 0; i < 4; i++) m_disp[i] = 0;
    end else if (m_valid) begin
      m_since++;
      if (m_left > 0) begin
        if (m_left == 1) m_disp = m_pend;
        m_left--;
      end else if (bus.load) begin
        m_left = VW + 1;
        if (int'(bus.value) > 9999) begin
          for (int i = 0; i < 4; i++) m_pend[i] = 31;
        end else begin
          m_pend[0] = int'(bus.value) % 10;
          m_pend[1] = (int'(bus.value) / 10) % 10;
          m_pend[2] = (int'(bus.value) / 100) % 10;
          m_pend[3] = (int'(bus.value) / 1000) % 10;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int e;
    if (m_valid) begin
      e = (m_since / RD) % 4;
      chk("model_ready", 32'(bus.ready), 32'(m_left == 0));
      chk("model_done", 32'(bus.done), 32'(m_left == 1));
      chk("model_exp", 32'(bus.exp), 32'(e));
      chk("model_in_digit", 32'(bus.in_digit), 32'(m_disp[e]));
    end
    if (!bus.ready) lo_cnt++;
    if (bus.done === 1'b1) begin
      if (done_cnt < 8) done_cyc[done_cnt] = cyc;
      done_cnt++;
    end
  end

  // Called at a negedge: presents load for exactly one cycle.
  task automatic do_load(input int v, output int t);
    bus.load  = 1'b1;
    bus.value = VW'(v);
    t         = cyc;
    lo_cnt    = 0;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int t);
    int n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (n >= 100) chk({nm, "_done_timeout"}, 32'(bus.done), 32'd1);
  endtask

  // Observe a full scan round and compare each position against literal digits.
  task automatic check_scan(input string nm, input int d0, input int d1, input int d2, input int d3);
    int seen [4];
    int changes = 0;
    logic [2:0] prev;
    for (int i = 0; i < 4; i++) seen[i] = -1;
    prev = bus.exp;
    repeat (4 * RD) begin
      @(negedge clk);
      seen[bus.exp[1:0]] = int'(bus.in_digit);
      if (bus.exp != prev) changes++;
      prev = bus.exp;
    end
    chk({nm, "_pos0"}, 32'(seen[0]), 32'(d0));
    chk({nm, "_pos1"}, 32'(seen[1]), 32'(d1));
    chk({nm, "_pos2"}, 32'(seen[2]), 32'(d2));
    chk({nm, "_pos3"}, 32'(seen[3]), 32'(d3));
    chk({nm, "_exp_steps"}, 32'(changes), 32'd4);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, dc;
    bus.load  = 1'b0;
    bus.value = '0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_exp", 32'(bus.exp), 32'd0);
    chk("rst_in_digit", 32'(bus.in_digit), 32'd0);
    rst = 1'b0;
    check_scan("rst_scan", 0, 0, 0, 0);

    // 1234: latency and scan order.
    do_load(1234, t0);
    wait_done("l1234", t1);
    chk("l1234_latency", 32'(t1 - t0), 32'd15);
    @(negedge clk);
    chk("l1234_ready_low", 32'(lo_cnt), 32'd15);
    chk("l1234_ready_back", 32'(bus.ready), 32'd1);
    check_scan("l1234", 4, 3, 2, 1);

    // 9999 then 0 back-to-back.
    dc = done_cnt;
    do_load(9999, t0);
    wait_done("l9999", t1);
    @(negedge clk);
    chk("l9999_digit", 32'(bus.in_digit), 32'd9);
    do_load(0, t0);
    wait_done("l0", t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd16);
    @(negedge clk);
    chk("b2b_done_count", 32'(done_cnt - dc), 32'd2);
    check_scan("l0", 0, 0, 0, 0);

    // Out of range.
    do_load(12000, t0);
    wait_done("l12000", t1);
    chk("l12000_latency", 32'(t1 - t0), 32'd15);
    @(negedge clk);
    check_scan("l12000", 31, 31, 31, 31);

    // Load ignored while busy.
    do_load(5678, t0);
    repeat (4) @(negedge clk);
    do_load(1111, t1);
    wait_done("l5678", t2);
    chk("l5678_latency", 32'(t2 - t0), 32'd15);
    @(negedge clk);
    check_scan("l5678", 8, 7, 6, 5);

    // Reset mid-conversion.
    dc = done_cnt;
    do_load(4321, t0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_exp", 32'(bus.exp), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - dc), 32'd0);
    check_scan("midrst", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
